rx_uart: RTL and testbench
==========================

# rx_uart

UART receiver: serial input, parallel output (SIPO). Recovers frames produced by the transmit path (start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit) from the asynchronous `serial_in` line. Oversamples at 16x the baud rate and checks parity and framing. Presents each received byte through a valid/ready handshake to the downstream consumer (host logic or RX FIFO).

## Interface
Parameters:
- `CLK_FREQ_HZ`, 48000000: system clock frequency.
- `BAUD_RATE`, 9600: line rate in bits/s.
- `DATA_WIDTH`, 8: data bits per frame.
- `PARITY_TYPE`, 0: 0 = even, 1 = odd. Used only when `RX_PARITY_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock, 48 MHz.
- `reset` input 1: synchronous, active-high; clears all state.
- `serial_in` input 1: asynchronous serial line; idles high.
- `i_ready` input 1: consumer accepts `o_data` when high in the same cycle as `o_valid`.
- `o_data` output DATA_WIDTH: received data; held stable while `o_valid` is high.
- `o_valid` output 1: a received word is available.
- `o_parity_err` output 1: parity mismatch for the word in `o_data`; qualified by `o_valid`.
- `o_frame_err` output 1: stop bit sampled low for the word in `o_data`; qualified by `o_valid`.
- `o_overrun` output 1: one-cycle pulse when a frame completes while `o_valid` is still high and not being accepted.
- `o_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `serial_in` passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized line `rx_s`.
- Tick divider: `DIV = CLK_FREQ_HZ / (BAUD_RATE*16)`, truncated (48 MHz / 9600 gives 312). It emits a one-cycle `tick` every DIV clocks and is cleared on the start-edge detect.
- A 4-bit `phase` counter counts ticks within a bit. A bit counter counts data bits.
- FSM states:
  - IDLE: when `rx_s` is 0, clear the divider and `phase`, then go to START.
  - START: at `phase`==7 (mid-bit), sample `rx_s`. If it is 1 this is a false start: go back to IDLE with no output. If it is 0, clear `phase` and go to DATA.
  - DATA: on each `phase`==15 tick, shift `rx_s` in at the MSB end (the line sends LSB first). After DATA_WIDTH samples, go to PARITY, or to STOP if parity is compiled out.
  - PARITY: on the `phase`==15 tick, sample the parity bit, then go to STOP.
  - STOP: on the `phase`==15 tick, sample the stop bit. Commit the result (see below) and go to IDLE in the same cycle. IDLE is therefore re-entered mid stop bit, so back-to-back frames are not lost.
- Commit (in the cycle the stop bit is sampled):
  - If `o_valid` is 0, or `i_ready` is 1 in this cycle: load `o_data`, `o_parity_err` and `o_frame_err`, and set `o_valid` to 1.
  - Otherwise: drop the new word, keep the old outputs, and pulse `o_overrun`.
- Handshake:
  - `o_valid` clears in the cycle after `o_valid` and `i_ready` are both high, unless a commit happens in that same cycle.
  - A word with errors is still delivered, with its flags set.
- Parity check: even parity requires the XOR of the data bits and the parity bit to equal 0. Odd parity requires it to equal 1.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_parity_err`=0, `o_frame_err`=0, `o_overrun`=0, `o_busy`=0. FSM is in IDLE, synchronizer flops are 1.
- Reset asserted mid-frame discards the frame at the next clock edge. The line is then re-acquired only after a new high-to-low transition reaches IDLE.
- Latency:
  - Start-bit falling edge to start detect: 2 or 3 clocks (synchronizer).
  - Start detect to `o_valid`: (8 + 16·(DATA_WIDTH+P+1))·DIV clocks + 1 clock, where P = 1 with parity and 0 without.
- Sample-point jitter: ±1 clock plus synchronizer delay. Tolerated baud mismatch is ±3%.
- A low glitch shorter than 8 ticks is rejected as a false start.
- A break (line held low) produces a word with `o_frame_err`=1. The receiver then waits in IDLE for the line to return to 1 before a new start is accepted.

## Configuration
- `RX_PARITY_EN` defined: the frame carries a parity bit after the data, the PARITY state exists, and `o_parity_err` reports mismatches per `PARITY_TYPE`.
- `RX_PARITY_EN` undefined: no PARITY state, and the frame is start + DATA_WIDTH + stop. `o_parity_err` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Oversample constant `OVERSAMPLE = 16` and mid-sample constant `MID_SAMPLE = 7`.
  - Divisor function `baud_div(clk_hz, baud)`, also used by the transmit-side baud generator.
- One sub-module, `rx_sample_tick`: parameterized divider with synchronous clear, producing `tick`.

## Test plan
Run with `RX_PARITY_EN` defined and even parity unless stated. The bench may override CLK_FREQ_HZ/BAUD_RATE so that DIV = 4.
- Valid frame: send 0xA5 with a correct parity bit (0) -> `o_valid`=1, `o_data`=0xA5, both error flags 0; accepted with `i_ready`=1, then `o_valid` returns to 0.
- Glitch: a low pulse of 5 ticks on an idle line -> no `o_valid`; `o_busy` returns to 0 by tick 8.
- Framing error: send 0x3C with the stop bit driven 0 -> `o_data`=0x3C, `o_frame_err`=1.
- Parity error: send 0x01 with the parity bit driven 0 -> `o_parity_err`=1; with `PARITY_TYPE`=1 the same frame gives `o_parity_err`=0.
- Overrun: send 0x11 then 0x22 back-to-back with `i_ready`=0 -> `o_data` stays 0x11 and `o_overrun` pulses once at the second stop sample.
- Reset mid-frame: assert `reset` during DATA of 0xFF -> all outputs 0 next cycle; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the baud divisor helper used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/rx_sample_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable
// by a synchronous clear so ticks line up with the start edge.
module rx_sample_tick #(
    parameter int DIV = 312
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_uart.sv
// UART receiver, 16x oversampled, with valid/ready output and error flags.
// Define RX_PARITY_EN to receive and check a parity bit after the data.
module rx_uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 48000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(DATA_WIDTH + 1);
    localparam logic [3:0] LAST_PHASE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_PHASE  = 4'(MID_SAMPLE);
    localparam logic PAR_ODD = (PARITY_TYPE != 0);

    rx_state_t state;
    rx_state_t state_next;

    logic                  sync0;
    logic                  rx_s;
    logic                  armed;
    logic [3:0]            phase;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bit;

    logic tick;
    logic clr_div;
    logic phase_clr;
    logic shift_en;
    logic par_en;
    logic commit;
    logic last_bit;
    logic bit_end;
    logic parity_bad;

    rx_sample_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clr_div),
        .tick (tick)
    );

    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign bit_end  = tick && (phase == LAST_PHASE);
    assign o_busy   = (state != IDLE);

`ifdef RX_PARITY_EN
    assign parity_bad = ((^shift_reg) ^ par_bit) != PAR_ODD;
`else
    // Parity compiled out: the flag can never be raised, whatever the type.
    assign parity_bad = 1'b0 & PAR_ODD;
`endif

    always_comb begin
        state_next = state;
        clr_div    = 1'b0;
        phase_clr  = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    clr_div    = 1'b1;
                    phase_clr  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick && phase == MID_PHASE) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        phase_clr  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is caught.
                if (bit_end) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sync0        <= 1'b1;
            rx_s         <= 1'b1;
            armed        <= 1'b0;
            phase        <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            sync0 <= serial_in;
            rx_s  <= sync0;
            state <= state_next;

            // A start is only honoured after the line has been seen high.
            if (commit) begin
                armed <= rx_s;
            end else if (rx_s) begin
                armed <= 1'b1;
            end

            if (phase_clr) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + 4'd1;
            end

            if (phase_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            end

            if (par_en) begin
                par_bit <= rx_s;
            end

            o_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (commit) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shift_reg;
                    o_parity_err <= parity_bad;
                    o_frame_err  <= !rx_s;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// Scoreboard bench for rx_uart: frames are pushed as expected words when
// sent and popped by a monitor whenever the DUT output is accepted.
module tb_rx_uart;

    localparam int CLK_HZ = 614400;
    localparam int BAUD   = 9600;
    localparam int DW     = 8;
    localparam int PT     = 0;
    localparam int DIVV   = CLK_HZ / (BAUD * 16);
    localparam int BITC   = 16 * DIVV;
`ifdef RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic          i_ready = 1'b1;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_parity_err;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   ovr_seen = 0;

    rx_uart #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW),
        .PARITY_TYPE(PT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", n, a, e);
        end
    endtask

    // Reference: the word as sent, parity judged by counting ones.
    function automatic exp_t model(input logic [7:0] d, input logic pbit,
                                   input logic stopb);
        exp_t e;
        int ones;
        ones = $countones(d) + int'(pbit);
        e.d  = d;
        e.fe = !stopb;
        e.pe = PEN ? ((ones % 2) != PT) : 1'b0;
        return e;
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2 != PT);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b);
        serial_in = b;
        repeat (BITC) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic stopb, input int gap, input bit push);
        if (push) q.push_back(model(d, pbit, stopb));
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(d[i]);
        if (PEN) drive(pbit);
        drive(stopb);
        serial_in = 1'b1;
        repeat (gap * BITC) step();
    endtask

    task automatic drain(input string n);
        int t;
        t = 0;
        while (q.size() != 0 && t < 20 * BITC) begin
            step();
            t++;
        end
        chk(n, 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (o_overrun) ovr_seen++;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got=%0h required=none", o_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("data", 32'(o_data), 32'(mon_e.d));
                    chk("parity_err", 32'(o_parity_err), 32'(mon_e.pe));
                    chk("frame_err", 32'(o_frame_err), 32'(mon_e.fe));
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       pb;
        logic       sb;
        int         gap;

        reset = 1'b1;
        repeat (4) step();
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_perr", 32'(o_parity_err), 32'd0);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        reset = 1'b0;
        repeat (BITC) step();

        // Valid frame
        send_frame(8'hA5, good_par(8'hA5), 1'b1, 2, 1'b1);
        drain("drain_a5");
        repeat (2) step();
        chk("valid_cleared", 32'(o_valid), 32'd0);

        // Glitch of 5 ticks
        serial_in = 1'b0;
        repeat (12) step();
        chk("glitch_busy", 32'(o_busy), 32'd1);
        repeat (5 * DIVV - 12) step();
        serial_in = 1'b1;
        repeat (45 - 5 * DIVV) step();
        chk("glitch_idle", 32'(o_busy), 32'd0);
        repeat (2 * BITC) step();

        // Framing error
        send_frame(8'h3C, good_par(8'h3C), 1'b0, 2, 1'b1);
        drain("drain_3c");

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1, 2, 1'b1);
        drain("drain_01");

        // Overrun: back-to-back with consumer stalled
        i_ready = 1'b0;
        send_frame(8'h11, good_par(8'h11), 1'b1, 0, 1'b1);
        send_frame(8'h22, good_par(8'h22), 1'b1, 2, 1'b0);
        chk("ovr_valid", 32'(o_valid), 32'd1);
        chk("ovr_data", 32'(o_data), 32'h11);
        chk("ovr_pulses", 32'(ovr_seen), 32'd1);
        i_ready = 1'b1;
        drain("drain_ovr");

        // Reset mid-frame discards the pending word and the frame
        i_ready = 1'b0;
        send_frame(8'h33, good_par(8'h33), 1'b1, 1, 1'b1);
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        drive(1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_ferr", 32'(o_frame_err), 32'd0);
        reset = 1'b0;
        q.delete();
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1);
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 2, 1'b1);
        drain("drain_5a");

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            d   = 8'($urandom);
            pb  = good_par(d) ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(0, 2);
            if (!sb && gap == 0) gap = 1;
            send_frame(d, pb, sb, gap, 1'b1);
        end
        repeat (2 * BITC) step();
        drain("drain_rand");
        chk("total_overruns", 32'(ovr_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
